// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg
// Shared types and helpers for the index register-file sequencer:
//   - op_e     : core micro-op encoding (6 and 7 are illegal)
//   - state_e  : sequencer states
//   - REG_W / PAIR_W / ADDR_W : register, pair and address widths
//   - incWrap  : 4-bit wrapping increment used by INC
//   - isPairOp / isLegal : opcode classification
package regfile_ctrl_pkg;

  localparam int REG_W  = 4;
  localparam int PAIR_W = 8;
  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    OP_RD  = 3'd0,
    OP_WR  = 3'd1,
    OP_RDP = 3'd2,
    OP_WRP = 3'd3,
    OP_INC = 3'd4,
    OP_XCH = 3'd5,
    OP_IL6 = 3'd6,
    OP_IL7 = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_WB   = 3'd2,
    S_RESP = 3'd3,
    S_DBG  = 3'd4,
    S_DACK = 3'd5
  } state_e;

  function automatic logic [REG_W-1:0] incWrap(input logic [REG_W-1:0] v);
    return v + REG_W'(1);
  endfunction

  function automatic logic isPairOp(input op_e op);
    return (op == OP_RDP) || (op == OP_WRP);
  endfunction

  function automatic logic isLegal(input op_e op);
    return op <= OP_XCH;
  endfunction

endpackage

// File: rtl/regfile_ctrl_arb.sv
// regfile_ctrl_arb
// IDLE-time grant decision between the core op port and the debug port.
// Debug wins when pending and the starve counter has reached
// DBG_STARVE_LIMIT, or when the core is not requesting. dbgBusy blocks a
// second debug grant until dbgReq has been seen low (4-phase handshake).
// Build option REGFILE_CTRL_DEBUG_EN: when undefined the core is always
// granted in IDLE and dbgReq is ignored.
// Ports:
//   clk, rstN            clock, async active-low reset
//   idle                 sequencer is in IDLE
//   cValid, dbgReq       requesters
//   grantCore, grantDbg  one-hot grants (only while idle)
//   coreReady            core may be accepted this cycle
module regfile_ctrl_arb
  import regfile_ctrl_pkg::*;
#(
  parameter int DBG_STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rstN,
  input  logic idle,
  input  logic cValid,
  input  logic dbgReq,
  output logic grantCore,
  output logic grantDbg,
  output logic coreReady
);

`ifdef REGFILE_CTRL_DEBUG_EN
  localparam int CW = $clog2(DBG_STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(DBG_STARVE_LIMIT);

  logic [CW-1:0] starveCnt;
  logic          dbgBusy;
  logic          pending;
  logic          debugWins;

  function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
    return (v == LIMIT_C) ? v : v + CW'(1);
  endfunction

  assign pending   = dbgReq & ~dbgBusy;
  assign debugWins = pending & ((starveCnt == LIMIT_C) | ~cValid);
  assign grantDbg  = idle & debugWins;
  assign grantCore = idle & cValid & ~debugWins;
  assign coreReady = idle & ~debugWins;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      starveCnt <= '0;
      dbgBusy   <= 1'b0;
    end else begin
      if (grantDbg)
        starveCnt <= '0;
      else if (grantCore && pending)
        starveCnt <= satInc(starveCnt);
      // Set on grant; released only once the requester has dropped dbgReq.
      if (grantDbg)
        dbgBusy <= 1'b1;
      else if (!dbgReq)
        dbgBusy <= 1'b0;
    end
  end
`else
  logic unusedArb;
  assign unusedArb = ^{clk, rstN, dbgReq, (DBG_STARVE_LIMIT > 0)};
  assign grantDbg  = 1'b0;
  assign grantCore = idle & cValid;
  assign coreReady = idle;
`endif

endmodule

// File: rtl/regfile_ctrl.sv
// regfile_ctrl
// Sequencer/arbiter in front of the 16x4-bit index register file. Accepts
// core micro-ops (RD, WR, RDP, WRP, INC, XCH) and debug single-register
// accesses, and drives the register file's single and pair ports. Single
// and pair writes are never asserted together; pair addresses are forced
// even. INC/XCH are sequenced as read (EXEC) then write (WB).
// Build option REGFILE_CTRL_DEBUG_EN enables the debug port; otherwise
// dbgAck/dbgRdata are tied 0 and debug inputs are ignored.
// Ports:
//   clk, rstN                          clock, async active-low reset
//   cValid/cReady/cOp/cAddr/cData      core op handshake and operands
//   rValid/rData/rZero/rErr            one-cycle core response
//   dbgReq/dbgWr/dbgAddr/dbgWdata      debug request (4-phase level)
//   dbgAck/dbgRdata                    debug completion and read data
//   rfReg*/rfPair*                     register-file control and read data
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int DBG_STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        cValid,
  output logic        cReady,
  input  logic [2:0]  cOp,
  input  logic [3:0]  cAddr,
  input  logic [7:0]  cData,
  output logic        rValid,
  output logic [7:0]  rData,
  output logic        rZero,
  output logic        rErr,
  input  logic        dbgReq,
  input  logic        dbgWr,
  input  logic [3:0]  dbgAddr,
  input  logic [3:0]  dbgWdata,
  output logic        dbgAck,
  output logic [3:0]  dbgRdata,
  output logic        rfRegWe,
  output logic [3:0]  rfRegAddr,
  output logic [3:0]  rfRegDin,
  output logic        rfPairWe,
  output logic [3:0]  rfPairAddr,
  output logic [7:0]  rfPairDin,
  input  logic [3:0]  rfRegDout,
  input  logic [7:0]  rfPairDout
);

  state_e              state, stateNext;
  op_e                 opReg;
  logic [ADDR_W-1:0]   addrReg;
  logic [PAIR_W-1:0]   dataReg;
  logic [PAIR_W-1:0]   capData;
  logic [ADDR_W-1:0]   pairAddr;
  logic [REG_W-1:0]    oldVal;
  logic [REG_W-1:0]    newVal;
  logic                idle;
  logic                grantCore;
  logic                grantDbg;
  logic                coreReady;

  assign idle     = (state == S_IDLE);
  assign pairAddr = {addrReg[ADDR_W-1:1], 1'b0};
  assign oldVal   = capData[REG_W-1:0];
  assign newVal   = incWrap(oldVal);
  // Held low during reset so every output reads 0 while rstN is asserted.
  assign cReady   = coreReady & rstN;

  regfile_ctrl_arb #(
    .DBG_STARVE_LIMIT(DBG_STARVE_LIMIT)
  ) u_arb (
    .clk       (clk),
    .rstN      (rstN),
    .idle      (idle),
    .cValid    (cValid),
    .dbgReq    (dbgReq),
    .grantCore (grantCore),
    .grantDbg  (grantDbg),
    .coreReady (coreReady)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)
      state <= S_IDLE;
    else
      state <= stateNext;
  end

  // Operand and read-capture registers carry data only; no reset needed
  // because RESP is reachable only through EXEC.
  always_ff @(posedge clk) begin
    if (grantCore) begin
      opReg   <= op_e'(cOp);
      addrReg <= cAddr;
      dataReg <= cData;
    end
    if (state == S_EXEC)
      capData <= isPairOp(opReg) ? rfPairDout : {4'b0, rfRegDout};
  end

`ifdef REGFILE_CTRL_DEBUG_EN
  logic [REG_W-1:0] dbgCap;

  always_ff @(posedge clk) begin
    if (state == S_DBG)
      dbgCap <= rfRegDout;
  end
`else
  logic unusedDbg;
  assign unusedDbg = ^{dbgWr, dbgAddr, dbgWdata};
  assign dbgAck    = 1'b0;
  assign dbgRdata  = '0;
`endif

  always_comb begin
    stateNext  = state;
    rfRegWe    = 1'b0;
    rfRegAddr  = '0;
    rfRegDin   = '0;
    rfPairWe   = 1'b0;
    rfPairAddr = '0;
    rfPairDin  = '0;
    rValid     = 1'b0;
    rData      = '0;
    rZero      = 1'b0;
    rErr       = 1'b0;
`ifdef REGFILE_CTRL_DEBUG_EN
    dbgAck     = 1'b0;
    dbgRdata   = '0;
`endif
    case (state)
      S_IDLE: begin
        if (grantCore)
          stateNext = S_EXEC;
        else if (grantDbg)
          stateNext = S_DBG;
      end
      S_EXEC: begin
        case (opReg)
          OP_RD, OP_INC, OP_XCH: rfRegAddr = addrReg;
          OP_WR: begin
            rfRegWe   = 1'b1;
            rfRegAddr = addrReg;
            rfRegDin  = dataReg[REG_W-1:0];
          end
          OP_RDP: rfPairAddr = pairAddr;
          OP_WRP: begin
            rfPairWe   = 1'b1;
            rfPairAddr = pairAddr;
            rfPairDin  = dataReg;
          end
          default: ;
        endcase
        stateNext = (opReg == OP_INC || opReg == OP_XCH) ? S_WB : S_RESP;
      end
      S_WB: begin
        rfRegWe   = 1'b1;
        rfRegAddr = addrReg;
        rfRegDin  = (opReg == OP_INC) ? newVal : dataReg[REG_W-1:0];
        stateNext = S_RESP;
      end
      S_RESP: begin
        rValid = 1'b1;
        rErr   = ~isLegal(opReg) | (isPairOp(opReg) & addrReg[0]);
        case (opReg)
          OP_RD, OP_RDP, OP_XCH: rData = capData;
          OP_INC: begin
            rData = {4'b0, newVal};
            rZero = (newVal == '0);
          end
          default: ;
        endcase
        stateNext = S_IDLE;
      end
`ifdef REGFILE_CTRL_DEBUG_EN
      S_DBG: begin
        rfRegAddr = dbgAddr;
        rfRegWe   = dbgWr;
        rfRegDin  = dbgWr ? dbgWdata : '0;
        stateNext = S_DACK;
      end
      S_DACK: begin
        dbgAck    = 1'b1;
        dbgRdata  = dbgCap;
        stateNext = S_IDLE;
      end
`endif
      default: stateNext = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl
// Directed bench for regfile_ctrl with a behavioural 16x4 register file
// (combinational reads, clocked writes, cleared by reset). Debug
// arbitration scenarios apply when REGFILE_CTRL_DEBUG_EN is defined;
// otherwise the bench confirms debug requests are ignored.
`timescale 1ns/1ps
module tb_regfile_ctrl;

  localparam logic [2:0] C_RD  = 3'd0;
  localparam logic [2:0] C_WR  = 3'd1;
  localparam logic [2:0] C_RDP = 3'd2;
  localparam logic [2:0] C_WRP = 3'd3;
  localparam logic [2:0] C_INC = 3'd4;
  localparam logic [2:0] C_XCH = 3'd5;

  logic       clk;
  logic       rstN;
  logic       cValid;
  logic       cReady;
  logic [2:0] cOp;
  logic [3:0] cAddr;
  logic [7:0] cData;
  logic       rValid;
  logic [7:0] rData;
  logic       rZero;
  logic       rErr;
  logic       dbgReq;
  logic       dbgWr;
  logic [3:0] dbgAddr;
  logic [3:0] dbgWdata;
  logic       dbgAck;
  logic [3:0] dbgRdata;
  logic       rfRegWe;
  logic [3:0] rfRegAddr;
  logic [3:0] rfRegDin;
  logic       rfPairWe;
  logic [3:0] rfPairAddr;
  logic [7:0] rfPairDin;
  logic [3:0] rfRegDout;
  logic [7:0] rfPairDout;

  logic [3:0] rf [16];

  int nChecks;
  int nErrors;

  int         respCyc;
  int         weCyc;
  int         pweCyc;
  int         nWe;
  logic [7:0] rdO;
  logic       zO;
  logic       errO;
  logic [3:0] weAddr;
  logic [3:0] weDin;
  logic [3:0] pweAddr;
  logic [7:0] pweDin;
  logic       bothWe;

  regfile_ctrl #(
    .DBG_STARVE_LIMIT(4)
  ) dut (
    .clk        (clk),
    .rstN       (rstN),
    .cValid     (cValid),
    .cReady     (cReady),
    .cOp        (cOp),
    .cAddr      (cAddr),
    .cData      (cData),
    .rValid     (rValid),
    .rData      (rData),
    .rZero      (rZero),
    .rErr       (rErr),
    .dbgReq     (dbgReq),
    .dbgWr      (dbgWr),
    .dbgAddr    (dbgAddr),
    .dbgWdata   (dbgWdata),
    .dbgAck     (dbgAck),
    .dbgRdata   (dbgRdata),
    .rfRegWe    (rfRegWe),
    .rfRegAddr  (rfRegAddr),
    .rfRegDin   (rfRegDin),
    .rfPairWe   (rfPairWe),
    .rfPairAddr (rfPairAddr),
    .rfPairDin  (rfPairDin),
    .rfRegDout  (rfRegDout),
    .rfPairDout (rfPairDout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: even register holds the pair's high nibble.
  assign rfRegDout  = rf[rfRegAddr];
  assign rfPairDout = {rf[rfPairAddr], rf[rfPairAddr + 4'd1]};

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < 16; i++) rf[i] <= 4'h0;
    end else begin
      if (rfRegWe) rf[rfRegAddr] <= rfRegDin;
      if (rfPairWe) begin
        rf[rfPairAddr]         <= rfPairDin[7:4];
        rf[rfPairAddr + 4'd1]  <= rfPairDin[3:0];
      end
    end
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outVec();
    return 64'({cReady, rValid, rData, rZero, rErr, dbgAck, dbgRdata,
                rfRegWe, rfRegAddr, rfRegDin, rfPairWe, rfPairAddr, rfPairDin});
  endfunction

  localparam logic [63:0] IDLE_VEC = 64'd1 << 38;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one core op from an IDLE cycle and observe up to six cycles
  // after the accepting edge (cycle 1 = first cycle after accept).
  task automatic runOp(input logic [2:0] op, input logic [3:0] addr, input logic [7:0] data);
    cValid = 1'b1;
    cOp    = op;
    cAddr  = addr;
    cData  = data;
    #1;
    checkVal("cReadyAtIssue", cReady, 1);
    tick();
    cValid = 1'b0;
    cOp    = 3'd0;
    cAddr  = 4'd0;
    cData  = 8'd0;
    respCyc = -1; weCyc = -1; pweCyc = -1; nWe = 0;
    rdO = 8'hxx; zO = 1'bx; errO = 1'bx;
    weAddr = 4'hx; weDin = 4'hx; pweAddr = 4'hx; pweDin = 8'hxx;
    for (int k = 1; k <= 6 && respCyc < 0; k++) begin
      #1;
      if (rfRegWe) begin weCyc = k; weAddr = rfRegAddr; weDin = rfRegDin; nWe++; end
      if (rfPairWe) begin pweCyc = k; pweAddr = rfPairAddr; pweDin = rfPairDin; nWe++; end
      if (rfRegWe && rfPairWe) bothWe = 1'b1;
      if (rValid) begin respCyc = k; rdO = rData; zO = rZero; errO = rErr; end
      tick();
    end
  endtask

  initial begin
    nChecks = 0; nErrors = 0; bothWe = 1'b0;
    rstN = 1'b0; cValid = 1'b0; cOp = 3'd0; cAddr = 4'd0; cData = 8'd0;
    dbgReq = 1'b0; dbgWr = 1'b0; dbgAddr = 4'd0; dbgWdata = 4'd0;

    #12;
    checkVal("rstOut", outVec(), 0);
    checkVal("rstReady", cReady, 0);
    #10 rstN = 1'b1;
    tick();
    checkVal("idleOut", outVec(), IDLE_VEC);

    runOp(C_WR, 4'd3, 8'h0A);
    checkVal("wrResp", respCyc, 2);
    checkVal("wrWeCyc", weCyc, 1);
    checkVal("wrWeAddr", weAddr, 4'd3);
    checkVal("wrWeDin", weDin, 4'hA);
    checkVal("wrData", rdO, 8'h00);
    checkVal("wrErr", errO, 0);

    runOp(C_RD, 4'd3, 8'h00);
    checkVal("rdResp", respCyc, 2);
    checkVal("rdData", rdO, 8'h0A);
    checkVal("rdErr", errO, 0);
    checkVal("rdNoWrite", nWe, 0);
    checkVal("idleOutAfterOps", outVec(), IDLE_VEC);

    runOp(C_WRP, 4'd4, 8'h5C);
    checkVal("wrpResp", respCyc, 2);
    checkVal("wrpPweCyc", pweCyc, 1);
    checkVal("wrpAddr", pweAddr, 4'd4);
    checkVal("wrpDin", pweDin, 8'h5C);
    checkVal("wrpErr", errO, 0);
    runOp(C_RDP, 4'd4, 8'h00);
    checkVal("rdpData", rdO, 8'h5C);
    runOp(C_RD, 4'd4, 8'h00);
    checkVal("rdR4", rdO, 8'h05);
    runOp(C_RD, 4'd5, 8'h00);
    checkVal("rdR5", rdO, 8'h0C);

    runOp(C_WRP, 4'd5, 8'h3B);
    checkVal("wrpOddAddr", pweAddr, 4'd4);
    checkVal("wrpOddErr", errO, 1);
    runOp(C_RDP, 4'd4, 8'h00);
    checkVal("rdpAfterOdd", rdO, 8'h3B);
    runOp(C_RD, 4'd6, 8'h00);
    checkVal("rdR6Untouched", rdO, 8'h00);

    runOp(C_WR, 4'd7, 8'h0F);
    runOp(C_INC, 4'd7, 8'h00);
    checkVal("incWeCyc", weCyc, 2);
    checkVal("incWeAddr", weAddr, 4'd7);
    checkVal("incWeDin", weDin, 4'h0);
    checkVal("incResp", respCyc, 3);
    checkVal("incData", rdO, 8'h00);
    checkVal("incZero", zO, 1);
    checkVal("incErr", errO, 0);

    runOp(C_INC, 4'd3, 8'h00);
    checkVal("incBData", rdO, 8'h0B);
    checkVal("incBZero", zO, 0);
    runOp(C_RD, 4'd3, 8'h00);
    checkVal("rdR3AfterInc", rdO, 8'h0B);

    runOp(C_WR, 4'd2, 8'h06);
    runOp(C_XCH, 4'd2, 8'h09);
    checkVal("xchResp", respCyc, 3);
    checkVal("xchData", rdO, 8'h06);
    checkVal("xchWeCyc", weCyc, 2);
    checkVal("xchWeDin", weDin, 4'h9);
    checkVal("xchZero", zO, 0);
    runOp(C_RD, 4'd2, 8'h00);
    checkVal("rdR2AfterXch", rdO, 8'h09);

    runOp(3'd7, 4'd1, 8'hFF);
    checkVal("ill7Resp", respCyc, 2);
    checkVal("ill7Err", errO, 1);
    checkVal("ill7Writes", nWe, 0);
    checkVal("ill7Data", rdO, 8'h00);
    runOp(3'd6, 4'd2, 8'hFF);
    checkVal("ill6Err", errO, 1);
    checkVal("ill6Writes", nWe, 0);
    checkVal("noDualWrite", bothWe, 0);

`ifdef REGFILE_CTRL_DEBUG_EN
    begin : dbgTest
      int         accepts;
      int         acceptsBefore;
      int         dbgWrCyc;
      int         ackCyc;
      int         ackCnt;
      int         ackLat;
      int         weRd;
      logic       ready12;
      logic [3:0] rdv;
      accepts = 0; acceptsBefore = 0; dbgWrCyc = -1; ackCyc = -1; ackCnt = 0;
      ackLat = -1; weRd = 0; ready12 = 1'bx; rdv = 4'hx;
      cValid = 1'b1; cOp = C_RD; cAddr = 4'd0; cData = 8'd0;
      dbgReq = 1'b1; dbgWr = 1'b1; dbgAddr = 4'h9; dbgWdata = 4'hD;
      #1;
      for (int cyc = 0; cyc < 30; cyc++) begin
        if (cValid && cReady) begin
          accepts++;
          if (dbgWrCyc < 0) acceptsBefore++;
        end
        if (cyc == 12) ready12 = cReady;
        if (rfRegWe && rfRegAddr == 4'h9 && dbgWrCyc < 0) dbgWrCyc = cyc;
        if (dbgAck) begin
          ackCnt++;
          if (ackCyc < 0) ackCyc = cyc;
        end
        if (rfRegWe && rfPairWe) bothWe = 1'b1;
        tick();
      end
      cValid = 1'b0; dbgReq = 1'b0; dbgWr = 1'b0;
      checkVal("dbgCoreOpsBefore", acceptsBefore, 4);
      checkVal("dbgReadyBlocked", ready12, 0);
      checkVal("dbgWriteCyc", dbgWrCyc, 13);
      checkVal("dbgAckCyc", ackCyc, 14);
      checkVal("dbgNoRegrant", ackCnt, 1);
      checkVal("dbgCoreAccepts", accepts, 9);
      checkVal("dbgRegWritten", rf[9], 4'hD);
      repeat (3) tick();
      dbgReq = 1'b1; dbgWr = 1'b0; dbgAddr = 4'h9;
      #1;
      for (int k = 0; k < 8 && ackLat < 0; k++) begin
        if (dbgAck) begin ackLat = k; rdv = dbgRdata; end
        if (rfRegWe) weRd++;
        tick();
      end
      dbgReq = 1'b0;
      checkVal("dbgReadLat", ackLat, 2);
      checkVal("dbgReadData", rdv, 4'hD);
      checkVal("dbgReadNoWrite", weRd, 0);
    end
`else
    begin : noDbgTest
      int accepts;
      int ackCnt;
      int weCnt;
      accepts = 0; ackCnt = 0; weCnt = 0;
      cValid = 1'b1; cOp = C_RD; cAddr = 4'd0; cData = 8'd0;
      dbgReq = 1'b1; dbgWr = 1'b1; dbgAddr = 4'h9; dbgWdata = 4'hD;
      #1;
      for (int cyc = 0; cyc < 20; cyc++) begin
        if (cValid && cReady) accepts++;
        if (dbgAck || dbgRdata != 4'h0) ackCnt++;
        if (rfRegWe) weCnt++;
        tick();
      end
      cValid = 1'b0; dbgReq = 1'b0; dbgWr = 1'b0;
      checkVal("noDbgCoreAccepts", accepts, 7);
      checkVal("noDbgAck", ackCnt, 0);
      checkVal("noDbgWrite", weCnt, 0);
    end
`endif
    repeat (2) tick();

    // Reset during WB of INC r5 (r5 = 0xB, so WB carries 0xC).
    cValid = 1'b1; cOp = C_INC; cAddr = 4'd5; cData = 8'd0;
    #1;
    tick();
    cValid = 1'b0; cOp = 3'd0; cAddr = 4'd0;
    tick();
    checkVal("rstWbWe", {rfRegWe, rfRegDin}, {1'b1, 4'hC});
    rstN = 1'b0;
    #1;
    checkVal("rstAbortOut", outVec(), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkVal("rstHoldOut", outVec(), 0);
    end
    checkVal("rstRegCleared", rf[5], 4'h0);
    rstN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkVal("postRstIdle", outVec(), IDLE_VEC);
      tick();
    end
    runOp(C_RD, 4'd5, 8'h00);
    checkVal("postRstR5", rdO, 8'h00);
    checkVal("postRstResp", respCyc, 2);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
